// File: rtl/pconv_pkg.sv
// Shared constants, types and helpers for the partial-convolution MAC pipeline.
package pconv_pkg;

  // Operand interpretation selectors for the SIGNED parameter.
  localparam bit UNSIGNED_MODE = 1'b0;
  localparam bit SIGNED_MODE   = 1'b1;

  // Per-stage control tag travelling alongside the datapath.
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } stage_tag_t;

  // Result width: one full product plus enough guard bits to sum every
  // product of a group without overflow.
  function automatic int pconv_out_w(input int data_w, input int wgt_w,
                                     input int lanes, input int acc_groups);
    return data_w + wgt_w + $clog2(lanes * acc_groups);
  endfunction

  // LSB position of lane 'lane' inside a packed bus of 'elem_w'-bit elements.
  function automatic int lane_lsb(input int lane, input int elem_w);
    return lane * elem_w;
  endfunction

endpackage

// File: rtl/pconv_lane_mul.sv
// One lane of the MAC: registers data*weight when the beat is accepted.
// The product is DATA_W+WGT_W bits wide; in signed mode both operands are
// sign-extended to that width first, so the low bits of the modular product
// are the exact two's-complement result.
module pconv_lane_mul
  import pconv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int WGT_W  = 8,
  parameter bit SIGNED = UNSIGNED_MODE
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [DATA_W-1:0]         data,
  input  logic [WGT_W-1:0]          weight,
  output logic [DATA_W+WGT_W-1:0]   product
);

  localparam int PROD_W = DATA_W + WGT_W;

  logic [PROD_W-1:0] data_ext;
  logic [PROD_W-1:0] weight_ext;
  logic [PROD_W-1:0] product_next;

  // Extend both operands to product width and multiply.
  // NOTE: every variable is assigned on every path through an always_comb, so no latch can be inferred.
  always_comb begin
    if (SIGNED) begin
      data_ext   = PROD_W'($signed(data));
      weight_ext = PROD_W'($signed(weight));
    end else begin
      data_ext   = PROD_W'(data);
      weight_ext = PROD_W'(weight);
    end
    product_next = data_ext * weight_ext;
  end

  // Product register, loaded only on accepted beats so idle inputs are ignored.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else if (load) begin
      product <= product_next;
    end
  end

endmodule

// File: rtl/pconv_mac_pipe.sv
// Pipelined partial-convolution MAC: S1 registers LANES products on the
// accept edge, S2 registers their sum, S3 accumulates ACC_GROUPS beats and
// presents the finished result with a valid/ready handshake. A single
// global enable stalls all stages while a result waits for downstream.
module pconv_mac_pipe
  import pconv_pkg::*;
#(
  parameter int  LANES      = 3,
  parameter int  DATA_W     = 8,
  parameter int  WGT_W      = 8,
  parameter int  ACC_GROUPS = 3,
  parameter bit  SIGNED     = UNSIGNED_MODE,
  localparam int OUT_W      = pconv_out_w(DATA_W, WGT_W, LANES, ACC_GROUPS)
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [LANES*DATA_W-1:0]   i_data,
  input  logic [LANES*WGT_W-1:0]    i_weight,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [OUT_W-1:0]          o_pconv
);

  localparam int PROD_W = DATA_W + WGT_W;
  localparam int CNT_W  = (ACC_GROUPS > 1) ? $clog2(ACC_GROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_GROUPS - 1);

  logic              en;
  logic              accept;
  logic [CNT_W-1:0]  beat_cnt;
  stage_tag_t        s1_tag;
  stage_tag_t        s2_tag;
  logic [PROD_W-1:0] s1_prod [LANES];
  logic [OUT_W-1:0]  lane_sum;
  logic [OUT_W-1:0]  s2_sum;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  acc_next;

  // The pipeline only freezes when a finished result is refused downstream.
  assign en      = !(o_valid && !i_ready);
  assign o_ready = en;
  // A clear in the same cycle drops the offered beat.
  assign accept  = i_valid && en && !i_clear;

  // Beat position within the current group; wraps after the last beat.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt <= '0;
    end else if (i_clear) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + 1'b1;
    end
  end

  // S1 datapath: one registered multiplier per lane.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    pconv_lane_mul #(
      .DATA_W (DATA_W),
      .WGT_W  (WGT_W),
      .SIGNED (SIGNED)
    ) u_mul (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .load    (accept),
      .data    (i_data[lane_lsb(k, DATA_W) +: DATA_W]),
      .weight  (i_weight[lane_lsb(k, WGT_W) +: WGT_W]),
      .product (s1_prod[k])
    );
  end

  // S1 control: tag the beat with its first/last position in the group.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_tag <= '0;
    end else if (i_clear) begin
      s1_tag <= '0;
    end else if (en) begin
      s1_tag.valid <= accept;
      s1_tag.first <= (beat_cnt == '0);
      s1_tag.last  <= (beat_cnt == LAST_BEAT);
    end
  end

  // Lane adder: every product is widened to OUT_W before summing.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (SIGNED) lane_sum = lane_sum + OUT_W'($signed(s1_prod[k]));
      else        lane_sum = lane_sum + OUT_W'(s1_prod[k]);
    end
  end

  // S2: register the beat sum together with its tag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_tag <= '0;
      s2_sum <= '0;
    end else if (i_clear) begin
      s2_tag <= '0;
    end else if (en) begin
      s2_tag <= s1_tag;
      if (s1_tag.valid) s2_sum <= lane_sum;
    end
  end

  // Running total: a first beat restarts the group instead of adding to acc.
  always_comb begin
    if (s2_tag.first) acc_next = s2_sum;
    else              acc_next = acc + s2_sum;
  end

  // S3: accumulate, and on the last beat publish the result and reset acc.
  // Under en, o_valid is either consumed or empty, so it simply follows
  // whether a new result loads; back-to-back results need no bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc     <= '0;
      o_valid <= 1'b0;
      o_pconv <= '0;
    end else if (i_clear) begin
      acc     <= '0;
      o_valid <= 1'b0;
    end else if (en) begin
      o_valid <= s2_tag.valid && s2_tag.last;
      if (s2_tag.valid) begin
        if (s2_tag.last) begin
          o_pconv <= acc_next;
          acc     <= '0;
        end else begin
          acc <= acc_next;
        end
      end
    end
  end

endmodule
